// File: rtl/aes256_host_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : aes256_host_sequencer                                           |
// | Purpose  : Host-side initiator for the AES256 device. Takes one command    |
// |            (key, block, op) per valid/ready handshake, serialises it into  |
// |            device beats (key low, key high, data), waits for the device    |
// |            result strobe with a timeout, and returns the result on a       |
// |            valid/ready response port. An optional key cache skips the two  |
// |            key beats when the key has not changed since the last good load.|
// | Ports    : clk, resetn (async, active-low)                                 |
// |            cmd_valid/cmd_ready/cmd_op/cmd_key_load/cmd_key/cmd_data       |
// |            rsp_valid/rsp_ready/rsp_data/rsp_timeout                        |
// |            dev_ctrl_dataIn/dev_mod_en/dev_inp  (registered beat outputs)   |
// |            dev_ctrl_dataOut/dev_outp           (device result)             |
// |            busy                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module aes256_host_sequencer #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int KEY_CACHE      = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_op,
  input  logic         cmd_key_load,
  input  logic [255:0] cmd_key,
  input  logic [127:0] cmd_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_timeout,
  output logic         dev_ctrl_dataIn,
  output logic [1:0]   dev_mod_en,
  output logic [127:0] dev_inp,
  input  logic         dev_ctrl_dataOut,
  input  logic [127:0] dev_outp,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_KEY_LO = 3'd1,
    S_KEY_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WAIT   = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  // The counter holds the number of WAIT cycles already completed, so the
  // TIMEOUT_CYCLES-th WAIT cycle is the one where it equals TIMEOUT_CYCLES-1.
  localparam logic [15:0] c_tmo_last = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  c_mod_key  = 2'b10;

  state_t         r_state;
  state_t         w_next;
  logic           r_op;
  logic [255:0]   r_key;
  logic [127:0]   r_data;
  logic           r_cache_valid;
  logic [255:0]   r_cache_key;
  logic [15:0]    r_cnt;
  logic           r_beat;
  logic [1:0]     r_mod_en;
  logic [127:0]   r_inp;
  logic [127:0]   r_rsp_data;
  logic           r_rsp_timeout;
  logic           w_accept;
  logic           w_skip;
  logic           w_tmo;

  assign cmd_ready       = (r_state == S_IDLE);
  assign busy            = (r_state != S_IDLE);
  assign rsp_valid       = (r_state == S_RESP);
  assign rsp_data        = r_rsp_data;
  assign rsp_timeout     = r_rsp_timeout;
  assign dev_ctrl_dataIn = r_beat;
  assign dev_mod_en      = r_mod_en;
  assign dev_inp         = r_inp;

  assign w_accept = cmd_valid && (r_state == S_IDLE);
  assign w_skip   = (KEY_CACHE != 0) && !cmd_key_load && r_cache_valid &&
                    (cmd_key == r_cache_key);
  assign w_tmo    = (r_cnt == c_tmo_last);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = w_skip ? S_DATA : S_KEY_LO;
      S_KEY_LO: w_next = S_KEY_HI;
      S_KEY_HI: w_next = S_DATA;
      S_DATA:   w_next = S_WAIT;
      S_WAIT:   if (dev_ctrl_dataOut || w_tmo) w_next = S_RESP;
      S_RESP:   if (rsp_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Beat registers are loaded on the edge that enters the beat state, so the
  // beat is visible for exactly the cycle spent in KEY_LO / KEY_HI / DATA.
  // Payload and mod_en keep their last value once the strobe drops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_op          <= 1'b0;
      r_key         <= '0;
      r_data        <= '0;
      r_cache_valid <= 1'b0;
      r_cache_key   <= '0;
      r_cnt         <= '0;
      r_beat        <= 1'b0;
      r_mod_en      <= 2'b00;
      r_inp         <= '0;
      r_rsp_data    <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_beat <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op   <= cmd_op;
            r_key  <= cmd_key;
            r_data <= cmd_data;
            r_cnt  <= '0;
            r_beat <= 1'b1;
            if (w_skip) begin
              r_mod_en <= {1'b0, cmd_op};
              r_inp    <= cmd_data;
            end else begin
              r_mod_en <= c_mod_key;
              r_inp    <= cmd_key[127:0];
            end
          end
        end
        S_KEY_LO: begin
          r_beat   <= 1'b1;
          r_mod_en <= c_mod_key;
          r_inp    <= r_key[255:128];
        end
        S_KEY_HI: begin
          r_beat   <= 1'b1;
          r_mod_en <= {1'b0, r_op};
          r_inp    <= r_data;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 16'd1;
          // A result arriving on the timeout cycle takes priority.
          if (dev_ctrl_dataOut) begin
            r_rsp_data    <= dev_outp;
            r_rsp_timeout <= 1'b0;
            if (KEY_CACHE != 0) begin
              r_cache_valid <= 1'b1;
              r_cache_key   <= r_key;
            end
          end else if (w_tmo) begin
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b1;
            r_cache_valid <= 1'b0;
          end
        end
        S_RESP: begin
          if (rsp_ready) r_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
